// File: rtl/serial_pkg.sv
// Shared serial-line encodings for serial_frame_tx and the matching receiver.
// SERIAL_FRAME_TX_PARITY_EN adds the PARITY state encoding.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b011,
`ifdef SERIAL_FRAME_TX_PARITY_EN
    ST_PARITY = 3'b010,
`endif
    ST_STOP   = 3'b110
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: free-runs 0..CLKS_PER_BIT-1, tick in the terminal-count cycle.
// Latency: tick CLKS_PER_BIT-1 cycles after clear drops; no backpressure.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TERM = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W bits LSB first, [even parity], stop bit.
// Latency: line falls the cycle after acceptance; frame is (DATA_W+2[+1])*CLKS_PER_BIT cycles.
// Backpressure: ready only in IDLE; load while busy is dropped. Parity via SERIAL_FRAME_TX_PARITY_EN.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              x_out,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  state_t            ps_q, ns_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              tick;
  logic              timer_clear;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // Holding the timer cleared in IDLE aligns the first START cycle with count 0.
  assign timer_clear = (ps_q == ST_IDLE);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_q      <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      ps_q      <= ns_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    ns_d      = ps_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (ps_q)
      ST_IDLE: if (load) begin
        ns_d      = ST_START;
        shreg_d   = data_in;
        bit_cnt_d = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        par_d     = ^data_in;
`endif
      end
      ST_START: if (tick) begin
        ns_d      = ST_DATA;
        bit_cnt_d = '0;
      end
      ST_DATA: if (tick) begin
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          ns_d = ST_PARITY;
`else
          ns_d = ST_STOP;
`endif
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      ST_PARITY: if (tick) ns_d = ST_STOP;
`endif
      ST_STOP: if (tick) ns_d = ST_IDLE;
      default: ns_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_out = LINE_IDLE;
    ready = 1'b0;
    done  = 1'b0;
    case (ps_q)
      ST_IDLE:   ready = 1'b1;
      ST_START:  x_out = START_BIT;
      ST_DATA:   x_out = shreg_q[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
      ST_PARITY: x_out = par_q;
`endif
      ST_STOP: begin
        x_out = STOP_BIT;
        done  = tick;
      end
      default:   ready = 1'b1;
    endcase
  end

  assign busy = ~ready;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx (DATA_W=8, CLKS_PER_BIT=4 and =1 instances).
// Expected frames follow SERIAL_FRAME_TX_PARITY_EN when it is defined.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data_in, data1;
  logic       load, load1;
  logic       ready, x_out, busy, done;
  logic       ready1, x1, busy1, done1;
  int         tests = 0;
  int         fails = 0;
  int         nd;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .load(load),
    .ready(ready), .x_out(x_out), .busy(busy), .done(done)
  );

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .data_in(data1), .load(load1),
    .ready(ready1), .x_out(x1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 1 after the accepting edge; returns in the cycle after the frame.
  task automatic frame0(input string tag, input logic [7:0] d, input logic [7:0] new_data,
                        input int pulse_cycle, output int ndone);
    logic [10:0] bits;
    int          nb;
    int          cyc;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    nb        = 10;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    bits[9]   = ^d;
    nb        = 11;
`endif
    ndone = 0;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < 4; c++) begin
        cyc = i * 4 + c;
        if (cyc == 0) data_in = new_data;
        if (pulse_cycle >= 0 && cyc == pulse_cycle) load = 1'b1;
        if (pulse_cycle >= 0 && cyc == pulse_cycle + 1) load = 1'b0;
        chk($sformatf("%s x_out bit%0d c%0d", tag, i, c), x_out, bits[i]);
        chk($sformatf("%s busy bit%0d c%0d", tag, i, c), busy, 1'b1);
        chk($sformatf("%s done bit%0d c%0d", tag, i, c), done, (i == nb - 1) && (c == 3));
        if (done) ndone++;
        step();
      end
    end
  endtask

  initial begin
    logic [10:0] exp1;
    int          n1;

    reset_n = 1'b0;
    load    = 1'b0;
    load1   = 1'b0;
    data_in = 8'h00;
    data1   = 8'h00;
    #2;
    chk("rst x_out", x_out, 1'b1);
    chk("rst ready", ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst x1", x1, 1'b1);
    step();
    step();
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle x_out", x_out, 1'b1);
      chk("idle ready", ready, 1'b1);
      chk("idle busy", busy, 1'b0);
      chk("idle done", done, 1'b0);
    end

    // Single frame of A5; data_in scrambled right after acceptance.
    data_in = 8'hA5;
    load    = 1'b1;
    step();
    load    = 1'b0;
    chk("a5 ready low", ready, 1'b0);
    frame0("a5", 8'hA5, 8'h00, -1, nd);
    chk_int("a5 done count", nd, 1);
    chk("a5 ready after", ready, 1'b1);
    chk("a5 busy after", busy, 1'b0);
    chk("a5 line after", x_out, 1'b1);

    // load held high: 00 frame, one IDLE cycle, then FF frame.
    data_in = 8'h00;
    load    = 1'b1;
    step();
    frame0("zero", 8'h00, 8'hFF, -1, nd);
    chk_int("zero done count", nd, 1);
    chk("b2b idle ready", ready, 1'b1);
    chk("b2b idle line", x_out, 1'b1);
    step();
    load = 1'b0;
    frame0("ff", 8'hFF, 8'hFF, -1, nd);
    chk_int("ff done count", nd, 1);
    chk("ff ready after", ready, 1'b1);

    // load pulse during DATA must not create another frame.
    data_in = 8'h3C;
    load    = 1'b1;
    step();
    load    = 1'b0;
    frame0("3c", 8'h3C, 8'h3C, 20, nd);
    for (int i = 0; i < 8; i++) begin
      chk("3c post ready", ready, 1'b1);
      chk("3c post line", x_out, 1'b1);
      if (done) nd++;
      step();
    end
    chk_int("3c done count", nd, 1);

    // Asynchronous reset in the middle of bit 4 of 0x81.
    data_in = 8'h81;
    load    = 1'b1;
    step();
    load    = 1'b0;
    for (int i = 0; i < 21; i++) step();
    chk("81 bit4 line", x_out, 1'b0);
    chk("81 bit4 busy", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rst line", x_out, 1'b1);
    chk("async rst ready", ready, 1'b1);
    chk("async rst busy", busy, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("post rst line", x_out, 1'b1);
    chk("post rst ready", ready, 1'b1);
    data_in = 8'h01;
    load    = 1'b1;
    step();
    load    = 1'b0;
    frame0("01", 8'h01, 8'h01, -1, nd);
    chk_int("01 done count", nd, 1);
    chk("01 ready after", ready, 1'b1);

    // One clock per bit, payload 0x55.
`ifdef SERIAL_FRAME_TX_PARITY_EN
    exp1 = 11'b100_1010_1010;
    n1   = 11;
`else
    exp1 = 11'b010_1010_1010;
    n1   = 10;
`endif
    data1 = 8'h55;
    load1 = 1'b1;
    step();
    load1 = 1'b0;
    for (int i = 0; i < n1; i++) begin
      chk($sformatf("cpb1 x bit%0d", i), x1, exp1[i]);
      chk($sformatf("cpb1 busy bit%0d", i), busy1, 1'b1);
      chk($sformatf("cpb1 done bit%0d", i), done1, i == n1 - 1);
      step();
    end
    chk("cpb1 ready after", ready1, 1'b1);
    chk("cpb1 line after", x1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
